// File: rtl/alu_issue_stage_pkg.sv
// Shared decode constants and types for the ALU issue stage.
// The funct3 values follow the ALU result-mux order, so they pass straight through as alu_op.
package alu_issue_stage_pkg;

    localparam int DATA_W = 32;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
        logic              control;
        logic              legal;
    } operand_sel_t;

    // Only add/sub and the right shifts have an alternate (instr[30]) form.
    function automatic logic has_alt_form(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SR);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream instruction handshake, flush, and the registered operand bundle handed to the ALU.
interface alu_issue_stage_if;
    import alu_issue_stage_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_instr;
    logic [DATA_W-1:0] in_pc;
    logic [DATA_W-1:0] in_rs1;
    logic [DATA_W-1:0] in_rs2;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic              alu_control;
    logic              alu_lt;
    logic              alu_ltu;
    logic [4:0]        rd;
    logic              wb_en;
    logic              illegal;

    modport master (
        output in_valid, in_instr, in_pc, in_rs1, in_rs2, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, alu_control,
               alu_lt, alu_ltu, rd, wb_en, illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, in_rs1, in_rs2, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, alu_control,
               alu_lt, alu_ltu, rd, wb_en, illegal
    );

endinterface

// File: rtl/alu_issue_stage_imm_gen.sv
// Combinational I-type and U-type immediate extraction from the raw instruction word.
module imm_gen
    import alu_issue_stage_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] imm_u
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'h000};

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of the RV32I ALU: decodes OP/OP-IMM/LUI/AUIPC, selects operands,
// precomputes the compare flags and holds the result in a single valid/ready register.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus
);

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic [4:0]      rd_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_u_s;
    operand_sel_t    raw_s;
    operand_sel_t    sel_s;
    logic            lt_s;
    logic            ltu_s;
    logic            accept_s;

    assign opcode_s = bus.in_instr[6:0];
    assign funct3_s = bus.in_instr[14:12];
    assign funct7_s = bus.in_instr[31:25];
    assign rd_s     = bus.in_instr[11:7];

    imm_gen u_imm_gen (
        .instr (bus.in_instr),
        .imm_i (imm_i_s),
        .imm_u (imm_u_s)
    );

    // Format decode and operand selection; a non-11 low pair never matches any opcode constant.
    always_comb begin
        raw_s = '0;
        case (opcode_s)
            OPC_OP: begin
                raw_s.a       = bus.in_rs1;
                raw_s.b       = bus.in_rs2;
                raw_s.op      = funct3_s;
                raw_s.control = has_alt_form(funct3_s) ? bus.in_instr[30] : 1'b0;
                raw_s.legal   = (funct7_s == F7_BASE) ||
                                ((funct7_s == F7_ALT) && has_alt_form(funct3_s));
            end
            OPC_OPIMM: begin
                raw_s.a       = bus.in_rs1;
                raw_s.b       = imm_i_s;
                raw_s.op      = funct3_s;
                raw_s.control = (funct3_s == F3_SR) ? bus.in_instr[30] : 1'b0;
                case (funct3_s)
                    F3_SLL:  raw_s.legal = (funct7_s == F7_BASE);
                    F3_SR:   raw_s.legal = (funct7_s == F7_BASE) || (funct7_s == F7_ALT);
                    default: raw_s.legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                raw_s.b     = imm_u_s;
                raw_s.legal = 1'b1;
            end
            OPC_AUIPC: begin
                raw_s.a     = bus.in_pc;
                raw_s.b     = imm_u_s;
                raw_s.legal = 1'b1;
            end
            default: raw_s.legal = 1'b0;
        endcase
    end

    // Illegal encodings present zero operands and an ADD so the ALU sees a benign input.
    always_comb begin
        if (raw_s.legal) begin
            sel_s = raw_s;
        end else begin
            sel_s = '0;
        end
    end

    assign lt_s     = $signed(sel_s.a) < $signed(sel_s.b);
    assign ltu_s    = sel_s.a < sel_s.b;
    assign accept_s = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !bus.out_valid || bus.out_ready;

    // Holding register: reset beats flush, flush beats accept, otherwise drain or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_op      <= 3'b000;
            bus.alu_control <= 1'b0;
            bus.alu_lt      <= 1'b0;
            bus.alu_ltu     <= 1'b0;
            bus.rd          <= 5'd0;
            bus.wb_en       <= 1'b0;
            bus.illegal     <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (accept_s) begin
            bus.out_valid   <= 1'b1;
            bus.alu_a       <= sel_s.a;
            bus.alu_b       <= sel_s.b;
            bus.alu_op      <= sel_s.op;
            bus.alu_control <= sel_s.control;
            bus.alu_lt      <= lt_s;
            bus.alu_ltu     <= ltu_s;
            bus.rd          <= rd_s;
            bus.wb_en       <= sel_s.legal && (rd_s != 5'd0);
            bus.illegal     <= !sel_s.legal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an instruction-level reference model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        ctl;
        logic        lt;
        logic        ltu;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic m_valid = 1'b0;
    exp_t m_rec = '0;

    alu_issue_stage_if bus ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // What the stage must present for one instruction, straight from the ISA rules.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                        input logic [31:0] x1, input logic [31:0] x2);
        exp_t e;
        logic [6:0] opc = w[6:0];
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd0;
        logic [2:0] op = 3'd0;
        logic ctl = 1'b0;
        logic ok = 1'b0;
        if (opc == 7'h33) begin
            ok  = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            a   = x1;
            b   = x2;
            op  = f3;
            ctl = (f3 == 3'd0 || f3 == 3'd5) && w[30];
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1)      ok = (f7 == 7'h00);
            else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
            else                 ok = 1'b1;
            a   = x1;
            b   = 32'($signed(w[31:20]));
            op  = f3;
            ctl = (f3 == 3'd5) && w[30];
        end else if (opc == 7'h37) begin
            ok = 1'b1;
            b  = w & 32'hFFFF_F000;
        end else if (opc == 7'h17) begin
            ok = 1'b1;
            a  = pc;
            b  = w & 32'hFFFF_F000;
        end
        if (!ok) begin
            a = 32'd0; b = 32'd0; op = 3'd0; ctl = 1'b0;
        end
        e.a   = a;
        e.b   = b;
        e.op  = op;
        e.ctl = ctl;
        e.lt  = $signed(a) < $signed(b);
        e.ltu = a < b;
        e.rd  = w[11:7];
        e.wb  = ok && (w[11:7] != 5'd0);
        e.ill = !ok;
        return e;
    endfunction

    task automatic compare();
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("in_ready", 32'(bus.in_ready), 32'(!m_valid || bus.out_ready));
        if (m_valid) begin
            chk("alu_a", bus.alu_a, m_rec.a);
            chk("alu_b", bus.alu_b, m_rec.b);
            chk("alu_op", 32'(bus.alu_op), 32'(m_rec.op));
            chk("alu_control", 32'(bus.alu_control), 32'(m_rec.ctl));
            chk("alu_lt", 32'(bus.alu_lt), 32'(m_rec.lt));
            chk("alu_ltu", 32'(bus.alu_ltu), 32'(m_rec.ltu));
            chk("rd", 32'(bus.rd), 32'(m_rec.rd));
            chk("wb_en", 32'(bus.wb_en), 32'(m_rec.wb));
            chk("illegal", 32'(bus.illegal), 32'(m_rec.ill));
        end
    endtask

    // Advance one clock: update the model from the inputs seen at the edge, then check the DUT.
    task automatic tick();
        logic ready;
        @(posedge clk);
        ready = !m_valid || bus.out_ready;
        if (rst)
            m_valid = 1'b0;
        else if (bus.flush)
            m_valid = 1'b0;
        else if (bus.in_valid && ready) begin
            m_valid = 1'b1;
            m_rec   = ref_decode(bus.in_instr, bus.in_pc, bus.in_rs1, bus.in_rs2);
        end else if (bus.out_ready)
            m_valid = 1'b0;
        #1;
        compare();
    endtask

    task automatic drive(input logic [31:0] w, input logic [31:0] pc,
                         input logic [31:0] x1, input logic [31:0] x2);
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        bus.in_pc    = pc;
        bus.in_rs1   = x1;
        bus.in_rs2   = x2;
    endtask

    task automatic issue(input logic [31:0] w, input logic [31:0] pc,
                         input logic [31:0] x1, input logic [31:0] x2);
        drive(w, pc, x1, x2);
        tick();
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [6:0] pick_f7();
        int r = $urandom_range(0, 3);
        logic [31:0] v = $urandom;
        if (r < 2)  return 7'h00;
        if (r == 2) return 7'h20;
        return v[6:0];
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] w = $urandom;
        logic [31:0] v = $urandom;
        int k = $urandom_range(0, 7);
        case (k)
            0, 1: begin
                w[6:0]   = 7'h33;
                w[31:25] = pick_f7();
            end
            2, 3: begin
                w[6:0] = 7'h13;
                if (w[14:12] == 3'd1 || w[14:12] == 3'd5) w[31:25] = pick_f7();
            end
            4:       w[6:0] = 7'h37;
            5:       w[6:0] = 7'h17;
            6:       w[6:0] = v[6:0];
            default: w = v;
        endcase
        return w;
    endfunction

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_pc     = 32'd0;
        bus.in_rs1    = 32'd0;
        bus.in_rs2    = 32'd0;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_wb_en", 32'(bus.wb_en), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_lt_ltu", 32'({bus.alu_lt, bus.alu_ltu, bus.alu_control}), 32'd0);
        rst = 1'b0;
        tick();

        issue(32'h402081B3, 32'h0, 32'd5, 32'd7);
        chk("sub_valid", 32'(bus.out_valid), 32'd1);
        chk("sub_a", bus.alu_a, 32'd5);
        chk("sub_b", bus.alu_b, 32'd7);
        chk("sub_op", 32'(bus.alu_op), 32'd0);
        chk("sub_ctl", 32'(bus.alu_control), 32'd1);
        chk("sub_lt_ltu", 32'({bus.alu_lt, bus.alu_ltu}), 32'd3);
        chk("sub_rd", 32'(bus.rd), 32'd3);
        chk("sub_wb", 32'(bus.wb_en), 32'd1);

        issue(32'hFFF00093, 32'h0, 32'd0, 32'd0);
        chk("addi_b", bus.alu_b, 32'hFFFF_FFFF);
        chk("addi_ctl", 32'(bus.alu_control), 32'd0);
        chk("addi_lt", 32'(bus.alu_lt), 32'd0);
        chk("addi_ltu", 32'(bus.alu_ltu), 32'd1);

        issue(32'h4040D113, 32'h0, 32'h8000_0000, 32'd0);
        chk("srai_op", 32'(bus.alu_op), 32'd5);
        chk("srai_ctl", 32'(bus.alu_control), 32'd1);
        chk("srai_b", bus.alu_b, 32'h404);
        chk("srai_lt_ltu", 32'({bus.alu_lt, bus.alu_ltu}), 32'd2);

        issue(32'h12345297, 32'h100, 32'd9, 32'd9);
        chk("auipc_a", bus.alu_a, 32'h100);
        chk("auipc_b", bus.alu_b, 32'h1234_5000);
        chk("auipc_op", 32'(bus.alu_op), 32'd0);

        issue(32'h00001037, 32'h0, 32'd3, 32'd3);
        chk("lui_x0_wb", 32'(bus.wb_en), 32'd0);
        chk("lui_x0_ill", 32'(bus.illegal), 32'd0);
        chk("lui_x0_b", bus.alu_b, 32'h1000);

        issue(32'h00208463, 32'h0, 32'd1, 32'd2);
        chk("branch_ill", 32'({bus.illegal, bus.wb_en}), 32'd2);
        issue(32'h02109093, 32'h0, 32'd1, 32'd2);
        chk("slli_bad_ill", 32'(bus.illegal), 32'd1);
        issue(32'h4020F1B3, 32'h0, 32'd1, 32'd2);
        chk("and_alt_ill", 32'(bus.illegal), 32'd1);
        issue(32'h00108090, 32'h0, 32'd1, 32'd2);
        chk("low_bits_ill", 32'({bus.illegal, bus.wb_en}), 32'd2);
        tick();
        chk("drain_empty", 32'(bus.out_valid), 32'd0);

        // Backpressure: A is held while B waits, then B follows exactly once.
        bus.out_ready = 1'b0;
        issue(32'h00208233, 32'h0, 32'd10, 32'd20);
        drive(32'h0020C333, 32'h0, 32'hF0, 32'h0F);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_a", bus.alu_a, 32'd10);
            chk("bp_hold_rd", 32'(bus.rd), 32'd4);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_b_a", bus.alu_a, 32'hF0);
        chk("bp_b_op", 32'(bus.alu_op), 32'd4);
        chk("bp_b_rd", 32'(bus.rd), 32'd6);
        tick();
        chk("bp_no_dup", 32'(bus.out_valid), 32'd0);

        issue(32'h00208233, 32'h0, 32'd1, 32'd1);
        drive(32'h402083B3, 32'h0, 32'd4, 32'd2);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_kill", 32'(bus.out_valid), 32'd0);
        tick();
        chk("flush_gone", 32'(bus.out_valid), 32'd0);

        issue(32'h00208233, 32'h0, 32'd1, 32'd1);
        drive(32'h402083B3, 32'h0, 32'd4, 32'd2);
        rst       = 1'b1;
        bus.flush = 1'b1;
        tick();
        rst          = 1'b0;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_a", bus.alu_a, 32'd0);
        chk("midrst_rd", 32'(bus.rd), 32'd0);
        chk("midrst_flags", 32'({bus.alu_op, bus.wb_en, bus.illegal}), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] x1 = $urandom;
            logic [31:0] x2 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
            rst           = ($urandom_range(0, 199) == 0);
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            drive(gen_instr(), $urandom, x1, x2);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
